// File: rtl/aes_round_sequencer.sv
// Round-robin sequencer for the shared iterative AES encryption round datapath.
// Two requesters share one datapath; each block runs rounds 0..Nr and returns with its requester ID.
module aes_round_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [127:0] req0_data,
   input  logic [127:0] req1_data,
   input  logic [1:0]   req0_ksel,
   input  logic [1:0]   req1_ksel,
   output logic [127:0] dp_state,
   output logic [3:0]   dp_round,
   output logic         dp_first,
   output logic         dp_last,
   input  logic [127:0] dp_result,
   output logic         key_sel,
   output logic [127:0] out_data,
   output logic         out_valid,
   output logic         out_id,
   output logic         out_err,
   output logic         busy
);

   // Handshake: requester i transfers on a rising edge where req_valid[i] & req_ready[i];
   // req_ready is combinational, one-hot, and only ever high in IDLE outside reset.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

   state_t         state;
   state_t         state_nxt;
   logic           last_g;
   logic           key_sel_r;
   logic           grant_id;
   logic           accept;
   logic           round_done;
   logic [3:0]     round;
   logic [3:0]     nr;
   logic [3:0]     nr_sel;
   logic [127:0]   state_reg;
   logic [127:0]   grant_data;
   logic [1:0]     grant_ksel;

   // A lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      grant_id = req_valid[1];
      if (req_valid == 2'b11) grant_id = ~last_g;
   end

   assign accept     = (state == IDLE) && !rst && (req_valid != 2'b00);
   assign grant_data = grant_id ? req1_data : req0_data;
   assign grant_ksel = grant_id ? req1_ksel : req0_ksel;
   assign round_done = (round == nr);

   always_comb begin
      case (grant_ksel)
         2'd0:    nr_sel = 4'd10;
         2'd1:    nr_sel = 4'd12;
         default: nr_sel = 4'd14;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (grant_ksel == 2'd3) ? ERR : RUN;
         RUN:     if (round_done) state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      if (accept) req_ready = grant_id ? 2'b10 : 2'b01;
      busy     = (state != IDLE);
      dp_first = (state == RUN) && (round == 4'd0);
      dp_last  = (state == RUN) && round_done;
   end

   assign dp_state = state_reg;
   assign dp_round = round;
   assign key_sel  = key_sel_r;

   // Request inputs are sampled only on accept, so later changes cannot disturb a block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_g    <= 1'b1;
         key_sel_r <= 1'b0;
         round     <= 4'd0;
         nr        <= 4'd10;
         state_reg <= 128'd0;
         out_data  <= 128'd0;
         out_valid <= 1'b0;
         out_id    <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state_reg <= grant_data;
                  nr        <= nr_sel;
                  key_sel_r <= grant_id;
                  last_g    <= grant_id;
                  round     <= 4'd0;
               end
            end
            RUN: begin
               state_reg <= dp_result;
               round     <= round + 4'd1;
               if (round_done) begin
                  out_data  <= dp_result;
                  out_id    <= key_sel_r;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            ERR: begin
               out_data  <= 128'd0;
               out_id    <= key_sel_r;
               out_err   <= 1'b1;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round datapath, arbitration/timing model and
// an expected-result queue, with known-answer vectors for AES-128/192/256.
module tb_aes_round_sequencer;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic         clk;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [127:0] req0_data;
   logic [127:0] req1_data;
   logic [1:0]   req0_ksel;
   logic [1:0]   req1_ksel;
   logic [127:0] dp_state;
   logic [3:0]   dp_round;
   logic         dp_first;
   logic         dp_last;
   logic [127:0] dp_result;
   logic         key_sel;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_id;
   logic         out_err;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [127:0] rk0 [16];
   logic [127:0] rk1 [16];
   logic [127:0] dp_rk;

   logic [129:0] exp_q[$];
   int           exp_cyc_q[$];

   int   m_free = 0;
   int   m_acc = 0;
   int   m_nr = 10;
   logic m_last_g = 1'b1;
   logic m_legal = 1'b0;
   logic m_id = 1'b0;

   aes_round_sequencer dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req0_data(req0_data), .req1_data(req1_data), .req0_ksel(req0_ksel), .req1_ksel(req1_ksel),
      .dp_state(dp_state), .dp_round(dp_round), .dp_first(dp_first), .dp_last(dp_last),
      .dp_result(dp_result), .key_sel(key_sel), .out_data(out_data), .out_valid(out_valid),
      .out_id(out_id), .out_err(out_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES primitives ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic first, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   b [16];
      logic [127:0] o;
      if (first) return s ^ rk;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         if (last) begin
            for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
         end else begin
            a[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            a[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
            a[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
      return o ^ rk;
   endfunction

   task automatic set_key(input int who, input logic [255:0] key, input int nk);
      logic [31:0]  w [60];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] k;
      int           nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         k = 128'h0;
         if (r <= nr) k = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         if (who == 0) rk0[r] = k;
         else          rk1[r] = k;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic who, input int nr);
      logic [127:0] s;
      s = pt ^ (who ? rk1[0] : rk0[0]);
      for (int r = 1; r <= nr; r++) s = aes_round(s, who ? rk1[r] : rk0[r], 1'b0, r == nr);
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Shared round datapath as the DUT sees it.
   always_comb begin
      dp_rk     = key_sel ? rk1[dp_round] : rk0[dp_round];
      dp_result = aes_round(dp_state, dp_rk, dp_first, dp_last);
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin : monitor
      logic [1:0]   exp_ready;
      logic         g;
      logic         exp_busy;
      logic         in_run;
      logic [1:0]   ks;
      logic [127:0] d;
      logic [129:0] e;
      int           ec;
      int           er;
      if (rst) begin
         checks++;
         if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL ready_in_reset: req_ready=%b required 00", req_ready);
         end
         exp_q.delete();
         exp_cyc_q.delete();
         m_last_g = 1'b1;
         m_free = 0;
         m_acc = 0;
         m_legal = 1'b0;
      end else begin
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: out_valid at cycle %0d with nothing outstanding", cyc);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               if (cyc != ec || out_data !== e[127:0] || out_id !== e[128] || out_err !== e[129]) begin
                  errors++;
                  $display("FAIL sb_output: cyc=%0d data=%h id=%b err=%b required cyc=%0d data=%h id=%b err=%b",
                           cyc, out_data, out_id, out_err, ec, e[127:0], e[128], e[129]);
               end
            end
         end
         exp_busy = (cyc > m_acc) && (cyc < m_free);
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL busy: cyc=%0d busy=%b required %b", cyc, busy, exp_busy);
         end
         in_run = m_legal && (cyc >= m_acc + 1) && (cyc <= m_acc + 1 + m_nr);
         er = cyc - m_acc - 1;
         checks++;
         if (dp_first !== (in_run && er == 0) || dp_last !== (in_run && er == m_nr) ||
             (in_run && (dp_round !== er[3:0] || key_sel !== m_id))) begin
            errors++;
            $display("FAIL dp_ctrl: cyc=%0d first=%b last=%b round=%0d key_sel=%b required run=%b round=%0d key_sel=%b",
                     cyc, dp_first, dp_last, dp_round, key_sel, in_run, er, m_id);
         end
         exp_ready = 2'b00;
         g = req_valid[1];
         if (req_valid == 2'b11) g = ~m_last_g;
         if (cyc >= m_free && req_valid != 2'b00) exp_ready = g ? 2'b10 : 2'b01;
         checks++;
         if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL ready: cyc=%0d req_ready=%b required %b", cyc, req_ready, exp_ready);
         end
         if (exp_ready != 2'b00) begin
            ks = g ? req1_ksel : req0_ksel;
            d  = g ? req1_data : req0_data;
            m_last_g = g;
            m_acc    = cyc;
            m_id     = g;
            m_legal  = (ks != 2'd3);
            m_nr     = 10 + 2 * int'(ks);
            if (m_legal) begin
               m_free = cyc + m_nr + 2;
               exp_q.push_back({1'b0, g, aes_ref(d, g, m_nr)});
            end else begin
               m_free = cyc + 2;
               exp_q.push_back({1'b1, g, 128'h0});
            end
            exp_cyc_q.push_back(m_free);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(output int c, output logic id);
      logic found;
      found = 1'b0;
      c = -1;
      id = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != 2'b00) begin
            found = 1'b1;
            c = cyc;
            id = req_ready[1];
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL accept_timeout: no grant within 40 cycles (valid=%b)", req_valid);
      end
   endtask

   task automatic wait_out(output int c, output logic [127:0] d, output logic id, output logic err,
                           output int nf, output int nl);
      logic found;
      found = 1'b0;
      c = -1; d = 128'h0; id = 1'b0; err = 1'b0; nf = 0; nl = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (dp_first) nf++;
         if (dp_last) nl++;
         if (out_valid) begin
            found = 1'b1;
            c = cyc; d = out_data; id = out_id; err = out_err;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL out_timeout: no out_valid within 40 cycles");
      end
   endtask

   task automatic do_request(input logic who, input logic [127:0] data, input logic [1:0] ksel,
                             input logic scramble, output logic gid, output int lat,
                             output logic [127:0] d, output logic oid, output logic oerr,
                             output int nf, output int nl);
      int c;
      int co;
      repeat ($urandom_range(1, 4)) tick();
      if (who) begin
         req1_data = data; req1_ksel = ksel; req_valid = 2'b10;
      end else begin
         req0_data = data; req0_ksel = ksel; req_valid = 2'b01;
      end
      wait_accept(c, gid);
      tick();
      req_valid = 2'b00;
      if (scramble) begin
         req0_data = rand128();
         req0_ksel = 2'd2;
      end
      wait_out(co, d, oid, oerr, nf, nl);
      lat = co - c;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      req_valid = 2'b11;
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00) begin
         errors++; $display("FAIL reset_ready: req_ready=%b required 00", req_ready);
      end
      tick();
      rst = 1'b0;
      req_valid = 2'b00;
      @(negedge clk);
      checks++;
      if ({out_valid, out_err, out_id, busy, dp_first, dp_last, key_sel} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b err=%b id=%b busy=%b first=%b last=%b key_sel=%b required all 0",
                  out_valid, out_err, out_id, busy, dp_first, dp_last, key_sel);
      end
      checks++;
      if (out_data !== 128'h0 || dp_state !== 128'h0 || dp_round !== 4'd0) begin
         errors++;
         $display("FAIL reset_regs: out_data=%h dp_state=%h dp_round=%0d required 0", out_data, dp_state, dp_round);
      end
   endtask

   task automatic test_aes128();
      logic gid, oid, oerr;
      int lat, nf, nl;
      logic [127:0] d;
      do_request(1'b0, PT, 2'd0, 1'b0, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (gid !== 1'b0) begin errors++; $display("FAIL aes128_grant: got %b required 0", gid); end
      checks++;
      if (lat != 12) begin errors++; $display("FAIL aes128_latency: got %0d required 12", lat); end
      checks++;
      if (d !== CT128) begin errors++; $display("FAIL aes128_data: got %h required %h", d, CT128); end
      checks++;
      if (oid !== 1'b0 || oerr !== 1'b0) begin
         errors++; $display("FAIL aes128_id_err: id=%b err=%b required 0 0", oid, oerr);
      end
      checks++;
      if (nf != 1 || nl != 1) begin
         errors++; $display("FAIL aes128_first_last: first=%0d last=%0d required 1 1", nf, nl);
      end
   endtask

   task automatic test_aes192_256();
      logic gid, oid, oerr;
      int lat, nf, nl;
      logic [127:0] d;
      set_key(1, K192, 6);
      do_request(1'b1, PT, 2'd1, 1'b0, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (lat != 14 || d !== CT192) begin
         errors++; $display("FAIL aes192: lat=%0d data=%h required 14 %h", lat, d, CT192);
      end
      checks++;
      if (oid !== 1'b1 || oerr !== 1'b0 || nf != 1 || nl != 1) begin
         errors++; $display("FAIL aes192_ctrl: id=%b err=%b first=%0d last=%0d required 1 0 1 1", oid, oerr, nf, nl);
      end
      set_key(1, K256, 8);
      do_request(1'b1, PT, 2'd2, 1'b0, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (lat != 16 || d !== CT256) begin
         errors++; $display("FAIL aes256: lat=%0d data=%h required 16 %h", lat, d, CT256);
      end
      checks++;
      if (oid !== 1'b1 || oerr !== 1'b0) begin
         errors++; $display("FAIL aes256_id_err: id=%b err=%b required 1 0", oid, oerr);
      end
   endtask

   task automatic test_contention();
      int   c [4];
      logic id [4];
      set_key(1, K192, 6);
      tick();
      rst = 1'b1;
      req_valid = 2'b00;
      tick();
      rst = 1'b0;
      req0_ksel = 2'd0; req1_ksel = 2'd1;
      req0_data = rand128(); req1_data = rand128();
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_accept(c[k], id[k]);
         tick();
         req0_data = rand128();
         req1_data = rand128();
      end
      req_valid = 2'b00;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (id[k] !== ((k % 2) == 1)) begin
            errors++; $display("FAIL contention_order: grant %0d went to %b required %0d", k, id[k], k % 2);
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (c[k+1] - c[k] != ((k % 2 == 0) ? 12 : 14)) begin
            errors++; $display("FAIL contention_gap: gap %0d is %0d required %0d", k, c[k+1] - c[k],
                               (k % 2 == 0) ? 12 : 14);
         end
      end
      repeat (16) tick();
   endtask

   task automatic test_illegal();
      logic gid, oid, oerr;
      int lat, nf, nl;
      logic [127:0] d;
      do_request(1'b1, PT, 2'd3, 1'b0, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (lat != 2 || oerr !== 1'b1) begin
         errors++; $display("FAIL illegal_timing: lat=%0d err=%b required 2 1", lat, oerr);
      end
      checks++;
      if (d !== 128'h0 || oid !== 1'b1) begin
         errors++; $display("FAIL illegal_data: data=%h id=%b required 0 1", d, oid);
      end
      checks++;
      if (nf != 0 || nl != 0) begin
         errors++; $display("FAIL illegal_rounds: first=%0d last=%0d required 0 0", nf, nl);
      end
      do_request(1'b0, PT, 2'd0, 1'b0, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (lat != 12 || d !== CT128 || oerr !== 1'b0) begin
         errors++; $display("FAIL after_illegal: lat=%0d data=%h err=%b required 12 %h 0", lat, d, oerr, CT128);
      end
   endtask

   task automatic test_input_change();
      logic gid, oid, oerr;
      int lat, nf, nl;
      logic [127:0] d;
      do_request(1'b0, PT, 2'd0, 1'b1, gid, lat, d, oid, oerr, nf, nl);
      checks++;
      if (lat != 12 || d !== CT128 || oid !== 1'b0) begin
         errors++; $display("FAIL input_change: lat=%0d data=%h id=%b required 12 %h 0", lat, d, oid, CT128);
      end
   endtask

   task automatic test_reset_midop();
      int c, co, nf, nl;
      logic id, oid, oerr;
      logic [127:0] d;
      tick();
      req0_data = PT; req0_ksel = 2'd0; req_valid = 2'b01;
      wait_accept(c, id);
      tick();
      req_valid = 2'b00;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (out_data !== 128'h0 || dp_state !== 128'h0 || dp_round !== 4'd0 ||
          {out_valid, out_err, out_id, key_sel, busy} !== 5'b0) begin
         errors++;
         $display("FAIL midop_reset_vals: out_data=%h dp_state=%h round=%0d valid=%b err=%b id=%b key_sel=%b busy=%b required 0",
                  out_data, dp_state, dp_round, out_valid, out_err, out_id, key_sel, busy);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midop_quiet: cycle %0d out_valid=%b busy=%b required 0 0", i, out_valid, busy);
         end
      end
      tick();
      req1_data = rand128(); req1_ksel = 2'd2;
      req_valid = 2'b11;
      wait_accept(c, id);
      checks++;
      if (id !== 1'b0) begin errors++; $display("FAIL midop_tie: grant %b required 0", id); end
      tick();
      req_valid = 2'b00;
      wait_out(co, d, oid, oerr, nf, nl);
      checks++;
      if (co - c != 12 || d !== CT128) begin
         errors++; $display("FAIL midop_after: lat=%0d data=%h required 12 %h", co - c, d, CT128);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      req0_data = 128'h0; req1_data = 128'h0;
      req0_ksel = 2'd0;   req1_ksel = 2'd0;
      set_key(0, K128, 4);
      set_key(1, K192, 6);
      test_reset();
      test_aes128();
      test_aes192_256();
      test_contention();
      test_illegal();
      test_input_change();
      test_reset_midop();
      repeat (5) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: %0d results outstanding required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
